// File: rtl/serial_bit_source_pkg.sv
// Shared constants for the serial bit source.
// State encodings and default word width.
package serial_bit_source_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/serial_bit_source_if.sv
// Word-in / bit-out bundle for the serial bit source.
// master drives words, slave emits the serial stream.
interface serial_bit_source_if
  import serial_bit_source_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             x;
  logic             valid;
  logic             done;

  modport master (
    output load, din,
    input  ready, x, valid, done
  );

  modport slave (
    input  load, din,
    output ready, x, valid, done
  );

endinterface

// File: rtl/serial_bit_source_piso_shift_reg.sv
// Parallel-in serial-out register.
// so_d_o is the bit that will be at the head after this edge.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             so_d_o
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = din_i;
    end else if (shift_i) begin
      sreg_d = shifted;
    end
  end

  assign so_d_o = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/serial_bit_source.sv
// Word-to-bitstream source with a one-word holding buffer.
// x/valid/done are registered from the next-state view.
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic clk,
  input logic rst,
  serial_bit_source_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             ld_sr;
  logic             sh_sr;
  logic [WIDTH-1:0] ld_data;
  logic             nxt_bit;
  logic             last;
  logic             rdy;

  assign last = (cnt_q == LAST);
  assign rdy  = (state_q == ST_IDLE) | ~full_q;

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    ld_sr   = 1'b0;
    sh_sr   = 1'b0;
    ld_data = bus.din;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          ld_sr   = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // buffered word wins over a same-edge offer
        unique case (1'b1)
          !last: begin
            sh_sr = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (bus.load && rdy) begin
              hold_d = bus.din;
              full_d = 1'b1;
            end
          end
          last && full_q: begin
            ld_sr   = 1'b1;
            ld_data = hold_q;
            full_d  = 1'b0;
            cnt_d   = '0;
          end
          last && !full_q && bus.load: begin
            ld_sr = 1'b1;
            cnt_d = '0;
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == ST_SHIFT);
    x_d     = valid_d ? nxt_bit : IDLE_LEVEL;
    done_d  = valid_d && (cnt_d == LAST);
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld_sr),
    .shift_i (sh_sr),
    .din_i   (ld_data),
    .so_d_o  (nxt_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      full_q  <= 1'b0;
      hold_q  <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_LEVEL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = rdy;
  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Scoreboard bench for serial_bit_source.
// One MSB-first/idle-0 and one LSB-first/idle-1 instance.
module tb_serial_bit_source;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] e0;
  logic [1:0] e1;
  logic [7:0] det1;

  serial_bit_source_if #(.WIDTH(W)) bus0 ();
  serial_bit_source_if #(.WIDTH(W)) bus1 ();

  serial_bit_source #(
    .WIDTH      (W),
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  serial_bit_source #(
    .WIDTH      (W),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  // Called at posedge+1; the next posedge accepts the word.
  task automatic load0(input logic [W-1:0] d);
    bus0.load = 1'b1;
    bus0.din  = d;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      q0.push_back({(i == W - 1), d[W-1-i]});
    end
    #1 bus0.load = 1'b0;
  endtask

  task automatic load1(input logic [W-1:0] d);
    bus1.load = 1'b1;
    bus1.din  = d;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      q1.push_back({(i == W - 1), d[i]});
    end
    #1 bus1.load = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 64 && q0.size() > 0; i++) @(negedge clk);
    check("drain0_empty", q0.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain1();
    for (int i = 0; i < 64 && q1.size() > 0; i++) @(negedge clk);
    check("drain1_empty", q1.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("dut0_valid", bus0.valid, 1);
        check("dut0_x", bus0.x, e0[0]);
        check("dut0_done", bus0.done, e0[1]);
      end else begin
        check("dut0_idle_valid", bus0.valid, 0);
        check("dut0_idle_x", bus0.x, 0);
        check("dut0_idle_done", bus0.done, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("dut1_valid", bus1.valid, 1);
        check("dut1_x", bus1.x, e1[0]);
        check("dut1_done", bus1.done, e1[1]);
      end else begin
        check("dut1_idle_valid", bus1.valid, 0);
        check("dut1_idle_x", bus1.x, 1);
      end
      if (bus1.valid) det1 = {det1[6:0], bus1.x};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    det1      = '0;
    rst       = 1'b1;
    bus0.load = 1'b0;
    bus0.din  = '0;
    bus1.load = 1'b0;
    bus1.din  = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_ready", bus0.ready, 1);
    check("rst_valid", bus0.valid, 0);
    check("rst_x", bus0.x, 0);
    check("rst_done", bus0.done, 0);
    check("rst_x_idle1", bus1.x, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", bus0.ready, 1);

    // single word
    load0(8'hB4);
    drain0();

    // back-to-back with an ignored third offer
    load0(8'hB4);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_ready_pre", bus0.ready, 1);
    load0(8'h5A);
    check("b2b_ready_full", bus0.ready, 0);
    bus0.load = 1'b1;
    bus0.din  = 8'h33;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("ovf_ready", bus0.ready, 0);
    end
    bus0.load = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_ready_last", bus0.ready, 0);
    @(posedge clk);
    #1;
    check("b2b_ready_xfer", bus0.ready, 1);
    drain0();

    // direct load on the last-bit edge
    load0(8'hB4);
    repeat (7) @(posedge clk);
    #1;
    check("same_ready", bus0.ready, 1);
    load0(8'h0F);
    drain0();

    // reset mid-word drops both words
    load0(8'hB4);
    load0(8'h5A);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_x", bus0.x, 1);
    rst = 1'b0;
    q0.delete();
    #1;
    check("mid_rst_x", bus0.x, 0);
    check("mid_rst_valid", bus0.valid, 0);
    check("mid_rst_done", bus0.done, 0);
    check("mid_rst_ready", bus0.ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    load0(8'hFF);
    drain0();

    // LSB-first instance
    det1 = '0;
    load1(8'hB4);
    drain1();
    check("lsb_detector", det1, 8'h2D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
SERIAL_BIT_SOURCE -- requirements
Module: serial_bit_source

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (minimum 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 shifts out bit WIDTH-1 first, 0 shifts out bit 0 first.
REQ-003 The block SHALL have parameter IDLE_LEVEL, default 0, which is the level driven on x when no word is being shifted.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 load  input  1  word offer; accepted on a rising clk edge only when ready=1.
REQ-007 din  input  WIDTH  parallel word; sampled on the accepting edge.
REQ-008 ready  output  1  holding buffer is empty, so a word can be accepted this cycle.
REQ-009 x  output  1  serial bit stream, registered; feeds the sequence-detector x input directly.
REQ-010 valid  output  1  x carries a data bit this cycle.
REQ-011 done  output  1  one-cycle pulse during the cycle in which the last bit of a word is on x.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and SHIFT, plus a one-word holding buffer with a full flag.
REQ-013 In IDLE: x=IDLE_LEVEL, valid=0, done=0, ready=1.
REQ-014 In IDLE, an edge with load=1 SHALL load din into the shift register, clear the bit counter, and enter SHIFT; the first bit appears on x in the next cycle (latency 1).
REQ-015 In SHIFT, each bit SHALL be held on x for exactly one clock, with valid=1 and WIDTH bits per word.
REQ-016 In SHIFT, ready SHALL equal NOT(holding-full); an edge with load=1 and ready=1 SHALL capture din into the holding buffer.
REQ-017 At the edge ending the last bit, the holding buffer SHALL be checked first: if it is full, its contents move to the shift register and the buffer empties.
REQ-018 If the buffer is empty at that edge and load=1 on the same edge, din SHALL go directly to the shift register.
REQ-019 If neither REQ-017 nor REQ-018 applies, the FSM SHALL return to IDLE.
REQ-020 Back-to-back words SHALL produce a continuous stream with no gap cycle and valid held high.
REQ-021 load while ready=0 SHALL be ignored, with no corruption of the holding buffer or the shift register.
REQ-022 done SHALL assert exactly once per word, coincident with that word's last bit, including for back-to-back words.
REQ-023 The bit counter width SHALL be clog2(WIDTH); the counter SHALL run 0..WIDTH-1 and wrap to 0 on reload.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for clk, force: state=IDLE, holding buffer empty, shift register=0, counter=0, x=IDLE_LEVEL, valid=0, done=0, ready=1.
REQ-025 Reset asserted mid-word SHALL abandon both the word in flight and the buffered word.
REQ-026 After reset deasserts, the first edge with load=1 SHALL start a fresh word per REQ-014.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, SHIFT) and the default WIDTH constant.
REQ-028 The bit-select datapath SHALL be a single sub-module, piso_shift_reg (parallel load, shift enable, MSB_FIRST select, serial out); the FSM and holding buffer stay in the top level.
REQ-029 x, valid and done SHALL be driven from registers, not from combinational logic.

Verification
REQ-030 Single word, WIDTH=8, MSB_FIRST=1, din=8'hB4 loaded at edge N: x=1,0,1,1,0,1,0,0 in cycles N+1..N+8; done only in N+8; IDLE from N+9.
REQ-031 Back-to-back: 8'hB4 is shifting and 8'h5A is loaded during its third bit: 16 consecutive valid bits with 5A immediately after B4; ready=0 from the buffering edge until transfer; two done pulses.
REQ-032 Overflow: a third word offered while the buffer is full is ignored: ready=0 and the stream still outputs only B4 then 5A.
REQ-033 Same-edge load: load=1 with din=8'h0F exactly on the last-bit edge with the buffer empty: the first 0F bit follows B4 with no gap.
REQ-034 Reset mid-word: rst=0 during bit 4 gives x=IDLE_LEVEL and valid=0 within that cycle, before the next clk edge; after release and a new load of 8'hFF, x outputs eight 1s.
REQ-035 LSB_FIRST: MSB_FIRST=0 with din=8'hB4 gives x=0,0,1,0,1,1,0,1; end-to-end, a connected sequence detector sees exactly this serial order.
